// File: rtl/bus_width_increase.sv
// Narrow-to-wide ready/valid adapter: gathers RATIO input beats into one output word,
// flushing a partial word with a per-lane keep mask when input_last is seen.
module bus_width_increase #(
    parameter int SIZE_IN       = 8,
    parameter int SIZE_OUT      = 32,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          input_ready,
    input  logic                          input_valid,
    input  logic [SIZE_IN-1:0]            input_data,
    input  logic                          input_last,
    input  logic                          output_ready,
    output logic                          output_valid,
    output logic [SIZE_OUT-1:0]           output_data,
    output logic [SIZE_OUT/SIZE_IN-1:0]   output_keep,
    output logic                          output_last
);
    localparam int RATIO = SIZE_OUT / SIZE_IN;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((SIZE_OUT % SIZE_IN) != 0) begin : g_bad_ratio
        $error("bus_width_increase: SIZE_OUT must be a multiple of SIZE_IN");
    end

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SIZE_OUT-1:0] acc_q, acc_d;
    logic [RATIO-1:0]    acc_keep_q, acc_keep_d;
    logic [SIZE_OUT-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]    out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;

    logic [CW-1:0]       lane_s;
    logic [SIZE_OUT-1:0] beat_data_s;
    logic [RATIO-1:0]    beat_keep_s;
    logic                accept_s;
    logic                complete_s;

    assign input_ready  = !out_valid_q || output_ready;
    assign output_valid = out_valid_q;
    assign output_data  = out_data_q;
    assign output_keep  = out_keep_q;
    assign output_last  = out_last_q;

    // Place the incoming beat into its lane according to the endianness setting.
    always_comb begin
        lane_s      = cnt_q;
        beat_data_s = '0;
        beat_keep_s = '0;
        if (LITTLE_ENDIAN) begin
            lane_s = cnt_q;
        end else begin
            lane_s = CW'(RATIO - 1) - cnt_q;
        end
        for (int i = 0; i < RATIO; i++) begin
            beat_keep_s[i]                   = (lane_s == CW'(i));
            beat_data_s[i*SIZE_IN +: SIZE_IN] = (lane_s == CW'(i)) ? input_data : {SIZE_IN{1'b0}};
        end
    end

    // Next-state: drain the output register, then accumulate or complete a word.
    always_comb begin
        accept_s    = input_valid && input_ready;
        complete_s  = accept_s && ((cnt_q == CW'(RATIO - 1)) || input_last);
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        acc_keep_d  = acc_keep_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && output_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_keep_d  = '0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (complete_s) begin
            // A completing beat reloads the output even while it drains: no bubble.
            out_data_d  = acc_q | beat_data_s;
            out_keep_d  = acc_keep_q | beat_keep_s;
            out_last_d  = input_last;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_keep_d  = '0;
            cnt_d       = '0;
        end else if (accept_s) begin
            acc_d       = acc_q | beat_data_s;
            acc_keep_d  = acc_keep_q | beat_keep_s;
            cnt_d       = cnt_q + CW'(1);
        end else begin
            cnt_d       = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            acc_keep_q  <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            acc_keep_q  <= acc_keep_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_bus_width_increase.sv
// Scoreboard bench: little- and big-endian adapters share one input stream;
// expected words are queued as beats are driven and compared on each output transfer.
module tb_bus_width_increase;
    logic        clk = 1'b0;
    logic        reset;
    logic        input_valid, input_last, output_ready;
    logic [7:0]  input_data;
    logic        rdy_le, rdy_be, val_le, val_be, last_le, last_be;
    logic [31:0] data_le, data_be;
    logic [3:0]  keep_le, keep_be;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   stalls = 0;

    always #5 clk = ~clk;

    bus_width_increase #(.SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b1)) dut_le (
        .clk(clk), .reset(reset), .input_ready(rdy_le), .input_valid(input_valid),
        .input_data(input_data), .input_last(input_last), .output_ready(output_ready),
        .output_valid(val_le), .output_data(data_le), .output_keep(keep_le), .output_last(last_le));

    bus_width_increase #(.SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b0)) dut_be (
        .clk(clk), .reset(reset), .input_ready(rdy_be), .input_valid(input_valid),
        .input_data(input_data), .input_last(input_last), .output_ready(output_ready),
        .output_valid(val_be), .output_data(data_be), .output_keep(keep_be), .output_last(last_be));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rev_data(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = d[(3-i)*8 +: 8];
        return r;
    endfunction

    function automatic logic [3:0] rev_keep(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_t e;
        e.d = d; e.k = k; e.l = l;
        return e;
    endfunction

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        input_valid = 1'b1;
        input_data  = d;
        input_last  = l;
        n = 0;
        @(negedge clk);
        while (!rdy_le && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 64'd0, 64'd1);
        if (n > 0) stalls++;
        @(posedge clk); #1;
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    // Output monitor: every completed transfer pops one expected word.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && val_le && output_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(data_le), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("le_data", 64'(data_le), 64'(e.d));
                check("le_keep", 64'(keep_le), 64'(e.k));
                check("le_last", 64'(last_le), 64'(e.l));
                check("be_valid", 64'(val_be), 64'd1);
                check("be_data", 64'(data_be), 64'(rev_data(e.d)));
                check("be_keep", 64'(keep_be), 64'(rev_keep(e.k)));
                check("be_last", 64'(last_be), 64'(e.l));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; input_valid = 1'b0; input_last = 1'b0; input_data = 8'h00; output_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(val_le), 64'd0);
        check("rst_data",  64'(data_le), 64'd0);
        check("rst_keep",  64'(keep_le), 64'd0);
        check("rst_last",  64'(last_le), 64'd0);
        check("rst_ready", 64'(rdy_le), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        output_ready = 1'b1;

        // Full word, plus one-cycle latency after the completing beat.
        exp_q.push_back(mk(32'h44332211, 4'b1111, 1'b0));
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        check("pre_valid", 64'(val_le), 64'd0);
        send(8'h44, 1'b0);
        check("lat_valid", 64'(val_le), 64'd1);

        // Partial packet flush, then a single-lane packet starting at lane 0.
        exp_q.push_back(mk(32'h0000BBAA, 4'b0011, 1'b1));
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        exp_q.push_back(mk(32'h000000CC, 4'b0001, 1'b1));
        send(8'hCC, 1'b1);

        // Sustained streaming with no bubbles; last on the final beat of a full word.
        stalls = 0;
        exp_q.push_back(mk(32'h04030201, 4'b1111, 1'b0));
        exp_q.push_back(mk(32'h08070605, 4'b1111, 1'b1));
        for (int i = 1; i <= 8; i++) send(8'(i), (i == 8));
        check("stream_stalls", 64'(stalls), 64'd0);

        // Backpressure: output held, input blocked, back-to-back reload on release.
        exp_q.push_back(mk(32'h44332211, 4'b1111, 1'b0));
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        output_ready = 1'b0;
        input_valid = 1'b1; input_data = 8'h55; input_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", 64'(rdy_le), 64'd0);
            check("bp_valid", 64'(val_le), 64'd1);
            check("bp_data",  64'(data_le), 64'h44332211);
            check("bp_be_data", 64'(data_be), 64'h11223344);
        end
        @(posedge clk); #1;
        exp_q.push_back(mk(32'h00000055, 4'b0001, 1'b1));
        output_ready = 1'b1;
        @(negedge clk);
        check("rel_ready", 64'(rdy_le), 64'd1);
        @(posedge clk); #1;
        input_valid = 1'b0; input_last = 1'b0;
        check("reload_valid", 64'(val_le), 64'd1);
        @(negedge clk);
        @(posedge clk); #1;

        // Reset mid-word discards the partial accumulation.
        send(8'h11, 1'b0); send(8'h22, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_valid", 64'(val_le), 64'd0);
        check("mid_rst_data",  64'(data_le), 64'd0);
        check("mid_rst_keep",  64'(keep_le), 64'd0);
        exp_q.push_back(mk(32'h66778899, 4'b1111, 1'b0));
        send(8'h99, 1'b0); send(8'h88, 1'b0); send(8'h77, 1'b0); send(8'h66, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("idle_valid", 64'(val_le), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_width_increase.md
Name: bus_width_increase

Overview:
- Bus width adapter: accumulates beats from a narrower ready/valid bus and emits them as one word on a wider ready/valid bus.
- Counterpart of the team's wide-to-narrow adapter; sits upstream of it, e.g. byte stream -> 32-bit word -> downstream logic.
- Supports packet termination: `input_last` flushes a partial word with a per-lane keep mask.

Parameters:
SIZE_IN, 8, narrow input bus width in bits
SIZE_OUT, 32, wide output bus width in bits; must be an integer multiple of SIZE_IN (elaboration-time $error otherwise)
LITTLE_ENDIAN, 1, 1: first accepted beat lands in the LSB lane; 0: first beat lands in the MSB lane

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
input_ready  output  1  adapter can accept an input beat this cycle
input_valid  input  1  input beat present
input_data  input  SIZE_IN  input beat
input_last  input  1  beat is final of packet; completes the current word
output_ready  input  1  downstream accepts output word
output_valid  output  1  output word present
output_data  output  SIZE_OUT  assembled word
output_keep  output  RATIO (=SIZE_OUT/SIZE_IN)  per-lane valid mask, bit i covers bits [i*SIZE_IN +: SIZE_IN]
output_last  output  1  word ends a packet

Behaviour:
- Interface: one clock (`clk`); reset (`reset`) is synchronous and active-high.
- Reset state: `output_valid`=0, `output_data`=0, `output_keep`=0, `output_last`=0, lane counter=0, accumulator and accumulator keep cleared.
  - Reset mid-word discards the partial word; no output is produced for it.
- Storage:
  - Accumulator of RATIO-1 lanes plus lane counter `cnt` (0..RATIO-1).
  - Separate output register (`output_data`/`_keep`/`_last`/`_valid`).
- Handshake:
  - `input_ready` = !`output_valid` || `output_ready`. This is a combinational path from `output_ready`; it is independent of `input_valid`.
  - A transfer occurs on valid && ready at the clock edge on each side.
- Lane mapping: accepted beat at counter value k is written to lane k when LITTLE_ENDIAN=1, and to lane RATIO-1-k when LITTLE_ENDIAN=0. That lane's keep bit is set.
- Accept, not completing (`cnt`<RATIO-1 and !`input_last`):
  - Write the lane into the accumulator; `cnt`++.
  - The output register is unaffected, except that it is cleared if drained in the same cycle.
- Accept, completing (`cnt`==RATIO-1 or `input_last`=1):
  - Load the output register next cycle with accumulator lanes plus the current beat.
  - Keep = accumulator keep | current lane bit.
  - Lanes never written read 0 in `output_data`.
  - `output_last` = `input_last`; `output_valid`=1.
  - Clear accumulator and keep; `cnt`=0.
- Latency: completing beat accepted at edge N -> `output_valid`=1 after edge N.
- Output drain: on `output_valid` && `output_ready`, set `output_valid`=0 unless a completing beat is accepted in the same cycle. In that case the register reloads with the new word (back-to-back, no bubble).
- Throughput: one input beat per cycle sustained while `output_ready`=1; one output word every RATIO cycles.
- Backpressure:
  - While `output_valid`=1 and `output_ready`=0, `input_ready`=0.
  - The accumulator holds and nothing is lost.
  - Output signals are stable until accepted.
- `input_last` at `cnt`=0: emits a single-lane word (keep = one bit).
- `input_last` at `cnt`==RATIO-1: full word with `output_last`=1.
- `input_valid`=0: nothing changes except output drain.
- RATIO=1: every accepted beat is completing; the block behaves as a one-deep register slice with keep=1.
- The block never drops, duplicates or reorders beats.

Test Plan:
- SIZE_IN=8, SIZE_OUT=32, LE=1. Stream 0x11,0x22,0x33,0x44 with `output_ready`=1 -> `output_data`=0x44332211, keep=4'b1111, last=0, valid one cycle after the 4th accept.
- Same stream with LE=0 -> `output_data`=0x11223344, keep=4'b1111.
- LE=1. Beats 0xAA,0xBB with `input_last` on 0xBB -> `output_data`=0x0000BBAA, keep=4'b0011, last=1. The next beat 0xCC starts a fresh word at lane 0.
- Continuous 8 beats 0x01..0x08, `output_ready`=1 -> words 0x04030201 then 0x08070605. `input_ready` stays 1 throughout; no bubbles.
- Complete word 0x44332211; hold `output_ready`=0 for 5 cycles while `input_valid`=1 with 0x55.
  - Required: `input_ready`=0 and the output stable for all 5 cycles.
  - On release, 0x44332211 is accepted and 0x55 is accepted in the same cycle.
- Accept 0x11,0x22; assert `reset` one cycle -> all outputs 0. Then 0x99,0x88,0x77,0x66 -> 0x66778899 with keep=4'b1111 and no stale lanes.
